// File: rtl/trace_stream_receiver.sv
// Decodes packed trace packets from an AXI-Stream into instruction/PC/delta/counter fields,
// rebuilds absolute timestamps and buffers them in a two-entry skid stage with registered ready.
module trace_stream_receiver #(
  parameter int AXI_DATA_WIDTH           = 512,
  parameter int XLEN                     = 64,
  parameter int INSTR_WIDTH              = 32,
  parameter int CLK_COUNTER_WIDTH        = 64,
  parameter int NO_OF_PERFORMANCE_EVENTS = 37,
  parameter int COUNTER_WIDTH            = 8
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              S_AXIS_tvalid,
  output logic                                              S_AXIS_tready,
  input  logic [AXI_DATA_WIDTH-1:0]                         S_AXIS_tdata,
  input  logic                                              S_AXIS_tlast,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [INSTR_WIDTH-1:0]                            out_instr,
  output logic [XLEN-1:0]                                   out_pc,
  output logic [CLK_COUNTER_WIDTH-1:0]                      out_delta,
  output logic [CLK_COUNTER_WIDTH-1:0]                      out_timestamp,
  output logic [NO_OF_PERFORMANCE_EVENTS*COUNTER_WIDTH-1:0] out_counters,
  output logic                                              out_last,
  input  logic                                              clear_stats,
  output logic [31:0]                                       pkt_count,
  output logic [15:0]                                       last_count,
  output logic                                              err_zero_delta
);

  localparam int CNT_W     = NO_OF_PERFORMANCE_EVENTS * COUNTER_WIDTH;
  localparam int PC_LSB    = CNT_W;
  localparam int DELTA_LSB = CNT_W + XLEN;
  localparam int INSTR_LSB = CNT_W + XLEN + CLK_COUNTER_WIDTH;
  localparam int PKT_W     = INSTR_LSB + INSTR_WIDTH;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0]       instr;
    logic [XLEN-1:0]              pc;
    logic [CLK_COUNTER_WIDTH-1:0] delta;
    logic [CLK_COUNTER_WIDTH-1:0] ts;
    logic [CNT_W-1:0]             counters;
    logic                         last;
  } entry_t;

  occ_t                         state;
  occ_t                         state_next;
  entry_t                       out_q;
  entry_t                       skid_q;
  entry_t                       in_entry;
  logic [CLK_COUNTER_WIDTH-1:0] ts_acc;
  logic                         tready_q;
  logic                         accept;
  logic                         out_hs;

  generate
    if (AXI_DATA_WIDTH > PKT_W) begin : g_upper
      logic unused_tdata_upper;
      assign unused_tdata_upper = ^S_AXIS_tdata[AXI_DATA_WIDTH-1:PKT_W];
    end
  endgenerate

  assign S_AXIS_tready = tready_q;
  assign accept        = S_AXIS_tvalid & tready_q;
  assign out_valid     = (state != EMPTY);
  assign out_hs        = out_valid & out_ready;

  assign out_instr     = out_q.instr;
  assign out_pc        = out_q.pc;
  assign out_delta     = out_q.delta;
  assign out_timestamp = out_q.ts;
  assign out_counters  = out_q.counters;
  assign out_last      = out_q.last;

  always_comb begin
    in_entry.instr    = S_AXIS_tdata[INSTR_LSB +: INSTR_WIDTH];
    in_entry.pc       = S_AXIS_tdata[PC_LSB +: XLEN];
    in_entry.delta    = S_AXIS_tdata[DELTA_LSB +: CLK_COUNTER_WIDTH];
    in_entry.ts       = ts_acc + S_AXIS_tdata[DELTA_LSB +: CLK_COUNTER_WIDTH];
    in_entry.counters = S_AXIS_tdata[CNT_W-1:0];
    in_entry.last     = S_AXIS_tlast;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (accept) state_next = ONE;
      ONE: begin
        if (accept && !out_hs)      state_next = FULL;
        else if (!accept && out_hs) state_next = EMPTY;
      end
      FULL:    if (out_hs) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // Ready is registered from the next occupancy so it never depends on out_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      tready_q <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
      ts_acc   <= '0;
    end else begin
      state    <= state_next;
      tready_q <= (state_next != FULL);
      if (accept)
        ts_acc <= S_AXIS_tlast ? '0 : in_entry.ts;
      if (accept && (state == EMPTY || (state == ONE && out_hs)))
        out_q <= in_entry;
      else if (state == FULL && out_hs)
        out_q <= skid_q;
      if (accept && state == ONE && !out_hs)
        skid_q <= in_entry;
    end
  end

  // A clear in the same cycle as an accept drops that beat from the counts, but a zero delta still sets the flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count      <= '0;
      last_count     <= '0;
      err_zero_delta <= 1'b0;
    end else begin
      if (clear_stats) begin
        pkt_count  <= '0;
        last_count <= '0;
      end else if (accept) begin
        pkt_count <= pkt_count + 32'd1;
        if (S_AXIS_tlast)
          last_count <= last_count + 16'd1;
      end
      if (accept && in_entry.delta == '0)
        err_zero_delta <= 1'b1;
      else if (clear_stats)
        err_zero_delta <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trace_stream_receiver.sv
// Scoreboard bench for trace_stream_receiver: a driver pushes expected packets from a
// timestamp/statistics model, and an independent monitor pops and compares on each output handshake.
module tb_trace_stream_receiver;

  localparam int AXI_W = 512;
  localparam int XLEN  = 64;
  localparam int IW    = 32;
  localparam int CW    = 64;
  localparam int NEV   = 37;
  localparam int CNTW  = 8;
  localparam int C     = NEV * CNTW;

  logic             clk;
  logic             rst;
  logic             S_AXIS_tvalid;
  logic             S_AXIS_tready;
  logic [AXI_W-1:0] S_AXIS_tdata;
  logic             S_AXIS_tlast;
  logic             out_valid;
  logic             out_ready;
  logic [IW-1:0]    out_instr;
  logic [XLEN-1:0]  out_pc;
  logic [CW-1:0]    out_delta;
  logic [CW-1:0]    out_timestamp;
  logic [C-1:0]     out_counters;
  logic             out_last;
  logic             clear_stats;
  logic [31:0]      pkt_count;
  logic [15:0]      last_count;
  logic             err_zero_delta;

  trace_stream_receiver #(
    .AXI_DATA_WIDTH(AXI_W), .XLEN(XLEN), .INSTR_WIDTH(IW), .CLK_COUNTER_WIDTH(CW),
    .NO_OF_PERFORMANCE_EVENTS(NEV), .COUNTER_WIDTH(CNTW)
  ) dut (
    .clk(clk), .rst(rst),
    .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tready(S_AXIS_tready),
    .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tlast(S_AXIS_tlast),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_delta(out_delta),
    .out_timestamp(out_timestamp), .out_counters(out_counters), .out_last(out_last),
    .clear_stats(clear_stats), .pkt_count(pkt_count), .last_count(last_count),
    .err_zero_delta(err_zero_delta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0]   instr;
    logic [XLEN-1:0] pc;
    logic [CW-1:0]   delta;
    logic [CW-1:0]   ts;
    logic [C-1:0]    cnts;
    logic            last;
  } exp_t;

  exp_t        sb[$];
  logic [CW-1:0] ts_model;
  int unsigned pkt_model;
  int unsigned last_model;
  bit          err_model;
  int          tests;
  int          fails;
  bit          rand_done;

  task automatic checkOutput(input string name, input logic [C-1:0] actual, input logic [C-1:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [C-1:0] randCounters();
    logic [C-1:0] r;
    for (int k = 0; k < NEV; k++) r[k*CNTW +: CNTW] = CNTW'($urandom_range(0, 255));
    return r;
  endfunction

  // Drives one beat (called at a negedge), holds it until accepted, and records the expected packet.
  task automatic applyStimulus(input logic [IW-1:0] instr, input logic [XLEN-1:0] pc,
                               input logic [CW-1:0] delta, input logic last, input logic [C-1:0] cnts);
    logic [AXI_W-1:0] d;
    int waits;
    exp_t e;
    for (int k = 0; k < AXI_W/32; k++) d[k*32 +: 32] = $urandom;
    d[C-1:0]            = cnts;
    d[C +: XLEN]        = pc;
    d[C+XLEN +: CW]     = delta;
    d[C+XLEN+CW +: IW]  = instr;
    S_AXIS_tdata  = d;
    S_AXIS_tlast  = last;
    S_AXIS_tvalid = 1'b1;
    waits = 0;
    while (S_AXIS_tready !== 1'b1 && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (S_AXIS_tready !== 1'b1) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: got tready=%0b expected 1", S_AXIS_tready);
    end else begin
      e.instr = instr; e.pc = pc; e.delta = delta; e.cnts = cnts; e.last = last;
      e.ts = ts_model + delta;
      ts_model = last ? '0 : e.ts;
      sb.push_back(e);
      if (clear_stats) begin
        pkt_model = 0; last_model = 0; err_model = (delta == '0);
      end else begin
        pkt_model++;
        if (last) last_model++;
        if (delta == '0) err_model = 1'b1;
      end
    end
    @(negedge clk);
    S_AXIS_tvalid = 1'b0;
    S_AXIS_tlast  = 1'b0;
  endtask

  task automatic drain();
    int waits;
    out_ready = 1'b1;
    waits = 0;
    while (sb.size() != 0 && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(negedge clk);
  endtask

  // Monitor: pops on every output handshake and checks that held outputs stay stable.
  initial begin
    bit   hold_prev;
    exp_t held;
    exp_t e;
    hold_prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        hold_prev = 1'b0;
        continue;
      end
      if (hold_prev) begin
        checkOutput("hold_valid", out_valid, 1'b1);
        checkOutput("hold_pc", out_pc, held.pc);
        checkOutput("hold_ts", out_timestamp, held.ts);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_output: got pc=%0h expected no packet", out_pc);
        end else begin
          e = sb.pop_front();
          checkOutput("instr", out_instr, e.instr);
          checkOutput("pc", out_pc, e.pc);
          checkOutput("delta", out_delta, e.delta);
          checkOutput("timestamp", out_timestamp, e.ts);
          checkOutput("counters", out_counters, e.cnts);
          checkOutput("last", out_last, e.last);
        end
      end
      hold_prev = out_valid && !out_ready;
      held.pc = out_pc;
      held.ts = out_timestamp;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [C-1:0] cnts;
    tests = 0; fails = 0;
    ts_model = '0; pkt_model = 0; last_model = 0; err_model = 1'b0;
    rst = 1'b1; S_AXIS_tvalid = 1'b0; S_AXIS_tdata = '0; S_AXIS_tlast = 1'b0;
    out_ready = 1'b0; clear_stats = 1'b0; rand_done = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_tready", S_AXIS_tready, 1'b0);
    checkOutput("rst_valid", out_valid, 1'b0);
    checkOutput("rst_pkt", pkt_count, 32'd0);
    checkOutput("rst_last_cnt", last_count, 16'd0);
    checkOutput("rst_err", err_zero_delta, 1'b0);
    checkOutput("rst_ts", out_timestamp, 64'd0);
    checkOutput("rst_counters", out_counters, '0);
    rst = 1'b0;
    #1 checkOutput("tready_before_edge", S_AXIS_tready, 1'b0);
    @(negedge clk);
    checkOutput("tready_after_release", S_AXIS_tready, 1'b1);

    // Single decode with tdata-order counter placement
    cnts = randCounters();
    cnts[(NEV-1)*CNTW +: CNTW] = 8'h03;
    cnts[0 +: CNTW]            = 8'hA1;
    applyStimulus(32'h10500073, 64'h80000010, 64'd5, 1'b1, cnts);
    checkOutput("single_valid", out_valid, 1'b1);
    checkOutput("single_ts", out_timestamp, 64'd5);
    checkOutput("single_instr", out_instr, 32'h10500073);
    checkOutput("single_counter0", out_counters[C-CNTW +: CNTW], 8'h03);
    checkOutput("single_counter36", out_counters[0 +: CNTW], 8'hA1);
    checkOutput("single_pkt", pkt_count, 32'd1);
    checkOutput("single_last_cnt", last_count, 16'd1);
    out_ready = 1'b1;
    drain();

    // Accumulation and restart after tlast
    applyStimulus(32'h1, 64'h100, 64'd5, 1'b0, randCounters());
    applyStimulus(32'h2, 64'h104, 64'd7, 1'b0, randCounters());
    applyStimulus(32'h3, 64'h108, 64'd4, 1'b1, randCounters());
    applyStimulus(32'h4, 64'h10c, 64'd3, 1'b0, randCounters());
    drain();

    // Wrap-around of the accumulator
    applyStimulus(32'h5, 64'h110, 64'd1, 1'b1, randCounters());
    applyStimulus(32'h6, 64'h114, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, randCounters());
    drain();
    out_ready = 1'b0;
    applyStimulus(32'h7, 64'h118, 64'd5, 1'b1, randCounters());
    checkOutput("wrap_ts", out_timestamp, 64'd3);
    checkOutput("wrap_err", err_zero_delta, 1'b0);
    drain();

    // Backpressure mid-stream
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++)
          applyStimulus(32'h100 + 32'(i), 64'h2000 + 64'(i*4), 64'(i + 1), 1'b0, randCounters());
      end
      begin
        @(negedge clk);
        checkOutput("bp_tready_one", S_AXIS_tready, 1'b1);
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("bp_tready_full", S_AXIS_tready, 1'b0);
        checkOutput("bp_valid_full", out_valid, 1'b1);
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Sticky zero-delta flag and clear_stats interaction
    applyStimulus(32'h8, 64'h300, 64'd0, 1'b0, randCounters());
    checkOutput("err_set", err_zero_delta, 1'b1);
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    pkt_model = 0; last_model = 0; err_model = 1'b0;
    checkOutput("err_cleared", err_zero_delta, 1'b0);
    checkOutput("pkt_cleared", pkt_count, 32'd0);
    clear_stats = 1'b1;
    applyStimulus(32'h9, 64'h304, 64'd0, 1'b1, randCounters());
    clear_stats = 1'b0;
    checkOutput("err_wins_clear", err_zero_delta, 1'b1);
    checkOutput("pkt_clear_same_cycle", pkt_count, 32'd0);
    checkOutput("last_clear_same_cycle", last_count, 16'd0);
    drain();

    // Randomized traffic with random output backpressure
    rand_done = 1'b0;
    fork
      begin
        logic [CW-1:0] dl;
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 4) == 0) @(negedge clk);
          case ($urandom_range(0, 9))
            0:       dl = '0;
            1:       dl = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 20));
            default: dl = {32'($urandom_range(0, 3)), $urandom};
          endcase
          applyStimulus($urandom, {$urandom, $urandom}, dl, ($urandom_range(0, 7) == 0), randCounters());
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    checkOutput("rand_pkt_count", pkt_count, pkt_model);
    checkOutput("rand_last_count", last_count, 16'(last_model));
    checkOutput("rand_err", err_zero_delta, err_model);

    // Reset mid-operation with both entries occupied
    out_ready = 1'b0;
    applyStimulus(32'hA, 64'h400, 64'd11, 1'b0, randCounters());
    applyStimulus(32'hB, 64'h404, 64'd12, 1'b0, randCounters());
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_valid", out_valid, 1'b0);
    checkOutput("midrst_tready", S_AXIS_tready, 1'b0);
    checkOutput("midrst_pkt", pkt_count, 32'd0);
    checkOutput("midrst_err", err_zero_delta, 1'b0);
    sb.delete();
    ts_model = '0; pkt_model = 0; last_model = 0; err_model = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    applyStimulus(32'hC, 64'h500, 64'd9, 1'b0, randCounters());
    drain();
    checkOutput("post_rst_pkt", pkt_count, 32'd1);
    checkOutput("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
